// File: rtl/spi_frame_master.sv
// spi_frame_master: run/stop tick counter whose snapshots are shipped out as SPI frames
module spi_frame_master #(
   parameter int CNT_W    = 14,
   parameter int NBYTES   = (CNT_W + 7) / 8,
   parameter int TICK_DIV = 100_000,
   parameter int SCLK_DIV = 4,
   parameter int CPOL     = 0,
   parameter int CPHA     = 0,
   parameter int GAP_CYC  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_runstop,
   input  logic                i_clear,
   output logic                sclk,
   output logic                mosi,
   input  logic                miso,
   output logic                ss,
   output logic [CNT_W-1:0]    o_counter,
   output logic [2:0]          o_state,
   output logic [8*NBYTES-1:0] o_rx_data,
   output logic                o_rx_valid,
   output logic                o_busy,
   output logic                o_drop
);
   localparam int   W        = 8 * NBYTES;
   localparam int   DW       = $clog2(TICK_DIV);
   localparam int   HW       = SCLK_DIV > 1 ? $clog2(SCLK_DIV) : 1;
   localparam int   GW       = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
   localparam int   BW       = NBYTES > 1 ? $clog2(NBYTES) : 1;
   localparam logic IDLE_LVL = 1'(CPOL);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      GAP   = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t         state, state_nxt;
   logic           run;
   logic [DW-1:0]  div;
   logic [CNT_W-1:0] cnt, cnt_inc;
   logic           tick, cap;
   logic           pend_v;
   logic [W-1:0]   pend;
   logic [W-1:0]   tx_sh, rx_sh, rx_next;
   logic [HW-1:0]  hcnt;
   logic           half;
   logic [2:0]     bit_cnt;
   logic [BW-1:0]  byte_cnt;
   logic [GW-1:0]  gap_cnt;
   logic           mosi_r, drop_r;
   logic           half_end, bit_end, byte_end, last_byte, gap_end, shift_now, samp_now;

   assign cnt_inc   = cnt + 1'b1;
   assign tick      = run && div == DW'(TICK_DIV - 1);
   assign cap       = tick && !i_clear;
   assign half_end  = hcnt == HW'(SCLK_DIV - 1);
   assign bit_end   = state == SHIFT && half && half_end;
   assign byte_end  = bit_end && bit_cnt == 3'd7;
   assign last_byte = byte_cnt == BW'(NBYTES - 1);
   assign gap_end   = gap_cnt == GW'(GAP_CYC - 1);
   assign shift_now = CPHA != 0 ? (state == SHIFT && !half && hcnt == '0) : bit_end;
   assign samp_now  = state == SHIFT && hcnt == '0 && half == (CPHA != 0);
   assign rx_next   = samp_now ? {rx_sh[W-2:0], miso} : rx_sh;

   assign sclk       = (state == SHIFT && !half) ^ IDLE_LVL;
   assign ss         = !(state == LOAD || state == SHIFT || state == GAP);
   assign mosi       = mosi_r;
   assign o_counter  = cnt;
   assign o_state    = state;
   assign o_rx_valid = state == DONE;
   assign o_busy     = state != IDLE;
   assign o_drop     = drop_r;

   // run flag, tick divider and counter; a clear overrides a coincident tick
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         run <= 1'b0;
         div <= '0;
         cnt <= '0;
      end else begin
         run <= run ^ i_runstop;
         if (i_clear) begin
            div <= '0;
            cnt <= '0;
         end else if (run) begin
            div <= tick ? '0 : div + 1'b1;
            cnt <= tick ? cnt_inc : cnt;
         end
      end

   // one-deep snapshot slot; a capture while still holding an unconsumed value is a drop
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pend_v <= 1'b0;
         pend   <= '0;
         drop_r <= 1'b0;
      end else begin
         drop_r <= cap && pend_v && state != LOAD;
         if (cap) begin
            pend_v <= 1'b1;
            pend   <= W'(cnt_inc);
         end else if (state == LOAD)
            pend_v <= 1'b0;
      end

   // frame state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nxt;

   // frame sequencing: load, shift bytes with optional gaps, then report
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = pend_v ? LOAD : IDLE;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (byte_end) state_nxt = last_byte ? DONE : (GAP_CYC > 0 ? GAP : SHIFT);
         GAP:     state_nxt = gap_end ? SHIFT : GAP;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // SCLK phase timing, bit/byte/gap counting and the transmit/receive shifters
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         hcnt      <= '0;
         half      <= 1'b0;
         bit_cnt   <= '0;
         byte_cnt  <= '0;
         gap_cnt   <= '0;
         tx_sh     <= '0;
         rx_sh     <= '0;
         mosi_r    <= 1'b0;
         o_rx_data <= '0;
      end else begin
         hcnt    <= (state != SHIFT || half_end) ? '0 : hcnt + 1'b1;
         half    <= state == SHIFT && (half ^ half_end);
         gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
         rx_sh   <= rx_next;
         if (state == LOAD) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tx_sh    <= CPHA != 0 ? pend : {pend[W-2:0], 1'b0};
            if (CPHA == 0) mosi_r <= pend[W-1];
         end
         if (bit_end) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 1'b1;
         end
         if (shift_now) begin
            mosi_r <= tx_sh[W-1];
            tx_sh  <= {tx_sh[W-2:0], 1'b0};
         end
         if (state == DONE) mosi_r <= 1'b0;
         if (byte_end && last_byte) o_rx_data <= rx_next;
      end
endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: directed checks of three differently configured frame masters in loopback
module tb_spi_frame_master;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  rst = '1, runstop = '0, clear = '0;
   logic [2:0]  sclk_v, ss_v, mosi_v, rxv_v, busy_v, drop_v;
   logic [9:0]  cnt_v [3];
   logic [2:0]  st_v  [3];
   logic [15:0] rxd_v [3];

   spi_frame_master #(.CNT_W(10), .TICK_DIV(50), .SCLK_DIV(1), .CPOL(0), .CPHA(0), .GAP_CYC(2)) u_a (
      .clk(clk), .reset(rst[0]), .i_runstop(runstop[0]), .i_clear(clear[0]),
      .sclk(sclk_v[0]), .mosi(mosi_v[0]), .miso(mosi_v[0]), .ss(ss_v[0]),
      .o_counter(cnt_v[0]), .o_state(st_v[0]), .o_rx_data(rxd_v[0]), .o_rx_valid(rxv_v[0]),
      .o_busy(busy_v[0]), .o_drop(drop_v[0]));

   spi_frame_master #(.CNT_W(10), .TICK_DIV(20), .SCLK_DIV(4), .CPOL(1), .CPHA(1), .GAP_CYC(2)) u_b (
      .clk(clk), .reset(rst[1]), .i_runstop(runstop[1]), .i_clear(clear[1]),
      .sclk(sclk_v[1]), .mosi(mosi_v[1]), .miso(mosi_v[1]), .ss(ss_v[1]),
      .o_counter(cnt_v[1]), .o_state(st_v[1]), .o_rx_data(rxd_v[1]), .o_rx_valid(rxv_v[1]),
      .o_busy(busy_v[1]), .o_drop(drop_v[1]));

   spi_frame_master #(.CNT_W(10), .TICK_DIV(40), .SCLK_DIV(1), .CPOL(1), .CPHA(1), .GAP_CYC(0)) u_c (
      .clk(clk), .reset(rst[2]), .i_runstop(runstop[2]), .i_clear(clear[2]),
      .sclk(sclk_v[2]), .mosi(mosi_v[2]), .miso(mosi_v[2]), .ss(ss_v[2]),
      .o_counter(cnt_v[2]), .o_state(st_v[2]), .o_rx_data(rxd_v[2]), .o_rx_valid(rxv_v[2]),
      .o_busy(busy_v[2]), .o_drop(drop_v[2]));

   int n_chk = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // reference tick counter for instance b (20 clocks per tick, 10-bit wrap)
   logic b_go = 1'b0;
   int   b_div = 0, b_cnt = 0;
   always @(posedge clk)
      if (b_go) begin
         if (b_div == 19) begin
            b_div <= 0;
            b_cnt <= (b_cnt + 1) % 1024;
         end else
            b_div <= b_div + 1;
      end

   logic [2:0]  ss_q = '1, sclk_q = '0;
   logic [15:0] bits [3], want [3];
   int          frames [3] = '{0, 0, 0}, drops [3] = '{0, 0, 0};
   int          seq_a = 1, seq_c = 1, clr_n = 0, clr_used = 0;
   logic        c_hit = 1'b0;

   task automatic step();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         if (sclk_v[i] && !sclk_q[i] && !ss_v[i]) bits[i] = {bits[i][14:0], mosi_v[i]};
         if (!ss_v[i] && ss_q[i]) begin
            bits[i] = '0;
            want[i] = 16'(i == 0 ? seq_a : i == 1 ? b_cnt : seq_c);
            check($sformatf("load_state_%0d", i), st_v[i], 1);
            check($sformatf("load_busy_%0d", i), busy_v[i], 1);
         end
         if (drop_v[i]) drops[i]++;
         if (rxv_v[i]) begin
            check($sformatf("rx_data_%0d", i), rxd_v[i], want[i]);
            check($sformatf("mosi_frame_%0d", i), bits[i], want[i]);
            frames[i]++;
            if (i == 2 && want[i] == 16'h02A5) c_hit = 1'b1;
         end
      end
      if (rxv_v[0]) begin
         seq_a    = clr_n != clr_used ? 1 : (seq_a + 1) % 1024;
         clr_used = clr_n;
      end
      if (rxv_v[2]) seq_c = (seq_c + 1) % 1024;
      ss_q   = ss_v;
      sclk_q = sclk_v;
   endtask

   initial begin
      int f0;
      repeat (3) step();
      check("rst_state", st_v[0], 0);
      check("rst_ss", ss_v[0], 1);
      check("rst_sclk_a", sclk_v[0], 0);
      check("rst_mosi", mosi_v[0], 0);
      check("rst_cnt", cnt_v[0], 0);
      check("rst_rx_data", rxd_v[0], 0);
      check("rst_rx_valid", rxv_v[0], 0);
      check("rst_busy", busy_v[0], 0);
      check("rst_drop", drop_v[0], 0);
      check("rst_sclk_b", sclk_v[1], 1);
      check("rst_sclk_c", sclk_v[2], 1);
      rst = '0;
      step();
      runstop = '1;
      step();
      runstop = '0;
      b_go    = 1'b1;
      repeat (49) step();
      check("a_cnt_before_tick", cnt_v[0], 0);
      step();
      check("a_cnt_first_tick", cnt_v[0], 1);
      check("b_cnt_e50", cnt_v[1], 2);
      check("c_cnt_e50", cnt_v[2], 1);

      for (int k = 0; k < 60000 && cnt_v[0] != 10'h3FF; k++) step();
      check("a_reach_3ff", cnt_v[0], 10'h3FF);
      for (int k = 0; k < 60 && cnt_v[0] == 10'h3FF; k++) step();
      check("a_wrap", cnt_v[0], 0);
      for (int k = 0; k < 100 && !rxv_v[0]; k++) step();
      check("a_wrap_frame_seen", rxv_v[0], 1);
      check("a_wrap_frame", rxd_v[0], 0);

      for (int k = 0; k < 400 && cnt_v[0] != 10'd5; k++) step();
      for (int k = 0; k < 10 && ss_v[0]; k++) step();
      check("a_clr_in_frame", ss_v[0], 0);
      repeat (6) step();
      clear[0] = 1'b1;
      clr_n++;
      step();
      clear[0] = 1'b0;
      check("a_clr_cnt", cnt_v[0], 0);
      f0 = frames[0];
      for (int k = 0; k < 200 && frames[0] < f0 + 2; k++) step();
      check("a_clr_frames", frames[0], f0 + 2);

      for (int k = 0; k < 100 && ss_v[0]; k++) step();
      repeat (5) step();
      check("a_mid_shift", st_v[0], 2);
      f0 = frames[0];
      rst[0] = 1'b1;
      #1;
      check("a_rst_ss", ss_v[0], 1);
      check("a_rst_sclk", sclk_v[0], 0);
      check("a_rst_mosi", mosi_v[0], 0);
      check("a_rst_state", st_v[0], 0);
      check("a_rst_rx_valid", rxv_v[0], 0);
      repeat (3) step();
      rst[0] = 1'b0;
      repeat (60) step();
      check("a_rst_no_valid", frames[0], f0);
      check("a_rst_idle", st_v[0], 0);
      check("a_rst_cnt", cnt_v[0], 0);

      check("a_no_drop", drops[0], 0);
      check("b_drop_seen", drops[1] > 0, 1);
      check("b_frames", frames[1] > 100, 1);
      check("c_2a5_frame", c_hit, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
